// File: rtl/cycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cycle_sequencer
// Description : Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer
//               with memory timeout fault and debug cycle/retire counters.
// Revision    : 1.0 - initial release
// ============================================================================
module cycle_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   haltRequest,
  input  logic                   instrReady,
  input  logic                   memReady,
  input  logic                   memReadFlag,
  input  logic                   memWriteFlag,
  input  logic                   regWriteFlag,
  output logic                   fetchEnable,
  output logic                   decodeEnable,
  output logic                   executeEnable,
  output logic                   memoryEnable,
  output logic                   writeBackEnable,
  output logic                   pcUpdate,
  output logic                   busy,
  output logic                   busFault,
  output logic [2:0]             stateOut,
  output logic [COUNT_WIDTH-1:0] cycleCount,
  output logic [COUNT_WIDTH-1:0] instructionCount
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_FAULT     = 3'd6
  } state_t;

  localparam logic [7:0] C_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t                 r_state;
  logic                   r_memRead;
  logic                   r_memWrite;
  logic                   r_regWrite;
  logic [7:0]             r_wait;
  logic [COUNT_WIDTH-1:0] r_cycleCount;
  logic [COUNT_WIDTH-1:0] r_instrCount;

  logic w_memAccess;
  logic w_retire;
  logic w_busy;

  // A simultaneous read+write sequences as a load: both simply mean "visit MEMORY".
  assign w_memAccess = r_memRead | r_memWrite;

  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      S_EXECUTE:   w_retire = !w_memAccess && !r_regWrite;
      S_MEMORY:    w_retire = memReady && !r_regWrite;
      S_WRITEBACK: w_retire = 1'b1;
      default:     w_retire = 1'b0;
    endcase
  end

  assign w_busy = (r_state == S_FETCH)   || (r_state == S_DECODE) ||
                  (r_state == S_EXECUTE) || (r_state == S_MEMORY) ||
                  (r_state == S_WRITEBACK);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_memRead    <= 1'b0;
      r_memWrite   <= 1'b0;
      r_regWrite   <= 1'b0;
      r_wait       <= 8'd0;
      r_cycleCount <= '0;
      r_instrCount <= '0;
    end else begin
      if (w_busy)   r_cycleCount <= r_cycleCount + 1'b1;
      if (w_retire) r_instrCount <= r_instrCount + 1'b1;

      case (r_state)
        S_IDLE: begin
          if (start) r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (instrReady) r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_memRead  <= memReadFlag;
          r_memWrite <= memWriteFlag;
          r_regWrite <= regWriteFlag;
          r_state    <= S_EXECUTE;
        end
        S_EXECUTE: begin
          if (w_memAccess) begin
            r_wait  <= 8'd0;
            r_state <= S_MEMORY;
          end else if (r_regWrite) begin
            r_state <= S_WRITEBACK;
          end else begin
            r_state <= haltRequest ? S_IDLE : S_FETCH;
          end
        end
        S_MEMORY: begin
          // memReady is checked first so a completion on the last allowed cycle wins.
          if (memReady) begin
            if (r_regWrite) r_state <= S_WRITEBACK;
            else            r_state <= haltRequest ? S_IDLE : S_FETCH;
          end else if (r_wait == C_WAIT_LAST) begin
            r_state <= S_FAULT;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        S_WRITEBACK: begin
          r_state <= haltRequest ? S_IDLE : S_FETCH;
        end
        S_FAULT: begin
          r_state <= S_FAULT;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign fetchEnable      = (r_state == S_FETCH);
  assign decodeEnable     = (r_state == S_DECODE);
  assign executeEnable    = (r_state == S_EXECUTE);
  assign memoryEnable     = (r_state == S_MEMORY);
  assign writeBackEnable  = (r_state == S_WRITEBACK);
  assign pcUpdate         = w_retire;
  assign busy             = w_busy;
  assign busFault         = (r_state == S_FAULT);
  assign stateOut         = r_state;
  assign cycleCount       = r_cycleCount;
  assign instructionCount = r_instrCount;

endmodule
`default_nettype wire

// File: tb/tb_cycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cycle_sequencer
// Description : Randomized self-checking bench with a per-instruction
//               timeline model for cycle_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cycle_sequencer;

  localparam int C_TIMEOUT = 15;
  localparam int C_CW      = 32;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic            haltRequest = 1'b0;
  logic            instrReady = 1'b0;
  logic            memReady = 1'b0;
  logic            memReadFlag = 1'b0;
  logic            memWriteFlag = 1'b0;
  logic            regWriteFlag = 1'b0;
  logic            fetchEnable, decodeEnable, executeEnable, memoryEnable;
  logic            writeBackEnable, pcUpdate, busy, busFault;
  logic [2:0]      stateOut;
  logic [C_CW-1:0] cycleCount, instructionCount;

  cycle_sequencer #(.MEM_TIMEOUT(C_TIMEOUT), .COUNT_WIDTH(C_CW)) dut (
    .clock(clock), .reset(reset), .start(start), .haltRequest(haltRequest),
    .instrReady(instrReady), .memReady(memReady), .memReadFlag(memReadFlag),
    .memWriteFlag(memWriteFlag), .regWriteFlag(regWriteFlag),
    .fetchEnable(fetchEnable), .decodeEnable(decodeEnable),
    .executeEnable(executeEnable), .memoryEnable(memoryEnable),
    .writeBackEnable(writeBackEnable), .pcUpdate(pcUpdate), .busy(busy),
    .busFault(busFault), .stateOut(stateOut), .cycleCount(cycleCount),
    .instructionCount(instructionCount)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] st;
    logic       pc;
    logic       s, ir, mr, h;
    logic       dec;
  } cyc_t;

  int     n_vec = 0;
  int     n_err = 0;
  longint m_cyc = 0;
  longint m_ins = 0;
  bit     m_idle = 1;
  cyc_t   q[$];

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic cyc_t mk(logic [2:0] st, logic pc, logic s, logic ir, logic mr, logic h, logic dec);
    cyc_t c;
    c.st = st; c.pc = pc; c.s = s; c.ir = ir; c.mr = mr; c.h = h; c.dec = dec;
    return c;
  endfunction

  function automatic logic [8:0] outs_for(logic [2:0] st, logic pc);
    return {st, pc, st == 3'd1, st == 3'd2, st == 3'd3, st == 3'd4, st == 3'd5,
            (st >= 3'd1 && st <= 3'd5), st == 3'd6};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; instrReady = 1'b0; memReady = 1'b0; haltRequest = 1'b0;
    tick();
    reset = 1'b0;
    m_cyc = 0; m_ins = 0; m_idle = 1;
  endtask

  // Builds the expected timeline of one instruction from its flags and wait
  // counts, then plays it against the DUT cycle by cycle.
  task automatic run_instr(input bit rd, input bit wr, input bit rw,
                           input int fwait, input int mwait, input bit halt);
    logic [8:0] obs, expv;
    bit mem, ret_ex;
    int nwait;
    q.delete();
    mem    = rd | wr;
    ret_ex = !mem && !rw;
    if (m_idle) q.push_back(mk(3'd0, 1'b0, 1'b1, rb(), rb(), rb(), 1'b0));
    for (int i = 0; i < fwait; i++) q.push_back(mk(3'd1, 1'b0, rb(), 1'b0, rb(), rb(), 1'b0));
    q.push_back(mk(3'd1, 1'b0, rb(), 1'b1, rb(), rb(), 1'b0));
    q.push_back(mk(3'd2, 1'b0, rb(), rb(), rb(), rb(), 1'b1));
    q.push_back(mk(3'd3, ret_ex, rb(), rb(), rb(), ret_ex ? halt : rb(), 1'b0));
    if (mem) begin
      nwait = (mwait < C_TIMEOUT) ? mwait : C_TIMEOUT;
      for (int i = 0; i < nwait; i++) q.push_back(mk(3'd4, 1'b0, rb(), rb(), 1'b0, rb(), 1'b0));
      if (mwait < C_TIMEOUT) q.push_back(mk(3'd4, !rw, rb(), rb(), 1'b1, !rw ? halt : rb(), 1'b0));
    end
    if (rw && !(mem && mwait >= C_TIMEOUT)) q.push_back(mk(3'd5, 1'b1, rb(), rb(), rb(), halt, 1'b0));

    foreach (q[k]) begin
      start = q[k].s; instrReady = q[k].ir; memReady = q[k].mr; haltRequest = q[k].h;
      if (q[k].dec) {memReadFlag, memWriteFlag, regWriteFlag} = {rd, wr, rw};
      else          {memReadFlag, memWriteFlag, regWriteFlag} = 3'($urandom);
      #2;
      obs  = {stateOut, pcUpdate, fetchEnable, decodeEnable, executeEnable,
              memoryEnable, writeBackEnable, busy, busFault};
      expv = outs_for(q[k].st, q[k].pc);
      n_vec++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL timeline rd=%0b wr=%0b rw=%0b step %0d: got %b expected %b",
                 rd, wr, rw, k, obs, expv);
      end
      if (q[k].st >= 3'd1 && q[k].st <= 3'd5) m_cyc++;
      if (q[k].pc) m_ins++;
      tick();
    end
    m_idle = halt;
    start = 1'b0;

    n_vec++;
    if (cycleCount !== C_CW'(m_cyc) || instructionCount !== C_CW'(m_ins)) begin
      n_err++;
      $display("FAIL counters: got cyc=%0d ins=%0d expected cyc=%0d ins=%0d",
               cycleCount, instructionCount, m_cyc, m_ins);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #2;
    n_vec++;
    if ({stateOut, fetchEnable, decodeEnable, executeEnable, memoryEnable, writeBackEnable,
         pcUpdate, busy, busFault} !== 11'd0 || cycleCount !== '0 || instructionCount !== '0) begin
      n_err++;
      $display("FAIL reset_state: got state=%0d busy=%0b cyc=%0d ins=%0d expected all 0",
               stateOut, busy, cycleCount, instructionCount);
    end
    tick();
  endtask

  task automatic test_add();
    do_reset();
    run_instr(0, 0, 1, 0, 0, 1);
    n_vec++;
    if (instructionCount !== 1 || cycleCount !== 4 || stateOut !== 3'd0) begin
      n_err++;
      $display("FAIL add: got ins=%0d cyc=%0d state=%0d expected 1 4 0",
               instructionCount, cycleCount, stateOut);
    end
  endtask

  task automatic test_load_store_branch();
    do_reset();
    run_instr(1, 0, 1, 0, 2, 1);
    n_vec++;
    if (cycleCount !== 7) begin
      n_err++;
      $display("FAIL ldur_cycles: got %0d expected 7", cycleCount);
    end
    do_reset();
    run_instr(0, 1, 0, 0, 0, 0);
    run_instr(0, 0, 0, 0, 0, 0);
    #2;
    n_vec++;
    if (instructionCount !== 2 || cycleCount !== 7 || stateOut !== 3'd1) begin
      n_err++;
      $display("FAIL stur_cbz: got ins=%0d cyc=%0d state=%0d expected 2 7 1",
               instructionCount, cycleCount, stateOut);
    end
    run_instr(1, 1, 0, 1, 0, 1);
  endtask

  task automatic test_random_program();
    do_reset();
    for (int n = 0; n < 40; n++) begin
      run_instr(($urandom % 3) == 0, ($urandom % 4) == 0, 1'($urandom),
                $urandom % 3, (($urandom % 8) == 0) ? C_TIMEOUT - 1 : $urandom % 4,
                ($urandom % 4) == 0);
    end
  endtask

  task automatic test_timeout_boundary();
    do_reset();
    run_instr(1, 0, 1, 0, C_TIMEOUT - 1, 0);
    run_instr(1, 0, 0, 0, C_TIMEOUT - 1, 1);
  endtask

  task automatic test_timeout_fault();
    logic [8:0] obs;
    do_reset();
    run_instr(1, 0, 1, 0, C_TIMEOUT, 0);
    for (int i = 0; i < 10; i++) begin
      start = rb(); instrReady = rb(); memReady = rb(); haltRequest = rb();
      #2;
      obs = {stateOut, pcUpdate, fetchEnable, decodeEnable, executeEnable,
             memoryEnable, writeBackEnable, busy, busFault};
      n_vec++;
      if (obs !== outs_for(3'd6, 1'b0) || cycleCount !== C_CW'(m_cyc) ||
          instructionCount !== C_CW'(m_ins)) begin
        n_err++;
        $display("FAIL fault_hold %0d: got %b cyc=%0d ins=%0d expected %b cyc=%0d ins=%0d",
                 i, obs, cycleCount, instructionCount, outs_for(3'd6, 1'b0), m_cyc, m_ins);
      end
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    #2;
    n_vec++;
    if (stateOut !== 3'd0 || busFault !== 1'b0 || busy !== 1'b0 ||
        cycleCount !== '0 || instructionCount !== '0) begin
      n_err++;
      $display("FAIL reset_in_fault: got state=%0d fault=%0b cyc=%0d expected 0 0 0",
               stateOut, busFault, cycleCount);
    end
    tick();
  endtask

  task automatic test_reset_in_memory();
    do_reset();
    start = 1'b1; tick();
    start = 1'b0; instrReady = 1'b1; tick();
    {memReadFlag, memWriteFlag, regWriteFlag} = 3'b101; tick();
    memReady = 1'b0; tick();
    tick();
    #2;
    n_vec++;
    if (stateOut !== 3'd4) begin
      n_err++;
      $display("FAIL reach_memory: got state=%0d expected 4", stateOut);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0; instrReady = 1'b0;
    #2;
    n_vec++;
    if ({stateOut, fetchEnable, decodeEnable, executeEnable, memoryEnable, writeBackEnable,
         pcUpdate, busy, busFault} !== 11'd0 || cycleCount !== '0 || instructionCount !== '0) begin
      n_err++;
      $display("FAIL reset_in_memory: got state=%0d mem=%0b cyc=%0d expected all 0",
               stateOut, memoryEnable, cycleCount);
    end
    tick();
  endtask

  task automatic test_fetch_stall();
    do_reset();
    start = 1'b1; tick();
    start = 1'b0; instrReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #2;
      n_vec++;
      if (stateOut !== 3'd1 || fetchEnable !== 1'b1 || cycleCount !== C_CW'(i)) begin
        n_err++;
        $display("FAIL fetch_stall %0d: got state=%0d fetch=%0b cyc=%0d expected 1 1 %0d",
                 i, stateOut, fetchEnable, cycleCount, i);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_store_branch();
    test_random_program();
    test_timeout_boundary();
    test_timeout_fault();
    test_reset_in_memory();
    test_fetch_stall();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cycle_sequencer.md
Name: cycle_sequencer

Overview:
Multi-cycle stage sequencer for the processor datapath. It replaces free-running single-cycle operation with an explicit FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequence and drives one enable per datapath unit: PC, instruction cache, controller, operand prep, ALU and data cache. It handles the ready handshakes from instruction and data memory, enforces a memory timeout, and keeps cycle and retired-instruction counters for the debug build.

Parameters:
MEM_TIMEOUT, 15, maximum cycles spent in MEMORY without memReady before fault (legal 1..255)
COUNT_WIDTH, 32, width of cycleCount and instructionCount

Ports:
clock  input  1  processor clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  begin execution; sampled only in IDLE
haltRequest  input  1  stop after the current instruction retires
instrReady  input  1  instruction cache word valid
memReady  input  1  data cache access complete
memReadFlag  input  1  from controller; valid during DECODE
memWriteFlag  input  1  from controller; valid during DECODE
regWriteFlag  input  1  from controller; valid during DECODE
fetchEnable  output  1  high in FETCH
decodeEnable  output  1  high in DECODE
executeEnable  output  1  high in EXECUTE
memoryEnable  output  1  high in MEMORY
writeBackEnable  output  1  high in WRITEBACK
pcUpdate  output  1  one-cycle pulse in the retiring cycle
busy  output  1  high in any state except IDLE and FAULT
busFault  output  1  high in FAULT
stateOut  output  3  current state encoding
cycleCount  output  COUNT_WIDTH  active-cycle counter
instructionCount  output  COUNT_WIDTH  retired-instruction counter

Behaviour:
- Reset is synchronous, active-high, on one clock, and takes priority over everything, including mid-MEMORY and FAULT. Next state is IDLE. All enables, pcUpdate, busy and busFault are 0. Both counters and the internal wait counter are 0.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, FAULT=6. Code 7 is unreachable and recovers to IDLE on the next edge.
- Stage enables are decoded from the state register (Moore). pcUpdate is a Mealy pulse and is combinational from state plus memReady.
- IDLE: if start=1, go to FETCH. Otherwise stay.
- FETCH: stay while instrReady=0. If instrReady=1, go to DECODE.
- DECODE: one cycle. memReadFlag, memWriteFlag and regWriteFlag are latched into internal registers on the exit edge. Flag changes after that are ignored. Go to EXECUTE.
- EXECUTE: one cycle. If latched memRead or memWrite is set, go to MEMORY. Else if latched regWrite is set, go to WRITEBACK. Else the instruction retires here.
- If memRead and memWrite are latched together, treat the instruction as a load with respect to sequencing.
- MEMORY: the wait counter clears on entry.
  - If memReady=1: go to WRITEBACK if latched regWrite is set, else retire.
  - If memReady=0 and the wait counter equals MEM_TIMEOUT-1: go to FAULT.
  - Otherwise increment the wait counter and stay.
  - memReady wins over timeout in the same cycle.
  - MEMORY therefore lasts at most MEM_TIMEOUT cycles.
- WRITEBACK: one cycle, then retire.
- Retire:
  - pcUpdate=1 during the retiring cycle.
  - instructionCount increments on that edge.
  - Next state is IDLE if haltRequest=1 in that cycle, else FETCH.
  - haltRequest outside a retiring cycle has no effect.
- FAULT: sticky until reset. No enables and no pcUpdate. Counters freeze.
- cycleCount increments on every edge where busy=1. Both counters wrap modulo 2^COUNT_WIDTH with no saturation.
- start is ignored outside IDLE.
- Nominal latency with no waits: 4 cycles for ALU ops, 3 for branch/no-write, 4 for store, 5 for load.

Test Plan:
- ADD (regWrite=1, mem=0), instrReady=1 throughout, start pulsed, haltRequest=1 -> states 1,2,3,5, then IDLE. pcUpdate high only in cycle 4. instructionCount=1, cycleCount=4.
- LDUR (memRead=1, regWrite=1), memReady asserted on the 3rd MEMORY cycle -> sequence 1,2,3,4,4,4,5. pcUpdate in WRITEBACK. cycleCount=7.
- STUR (memWrite=1, regWrite=0) followed by CBZ (no flags), haltRequest low, instrReady immediate -> STUR retires in MEMORY (cycle 4) and CBZ retires in EXECUTE (cycle 7). instructionCount=2. After the second pcUpdate the state returns to FETCH.
- Load with memReady held 0 and MEM_TIMEOUT=15 -> exactly 15 MEMORY cycles, then stateOut=6 and busFault=1. No pcUpdate. Counters frozen for 10 further cycles.
- memReady=1 on the 15th MEMORY cycle (timeout boundary) -> no fault; proceeds to WRITEBACK.
- reset=1 during MEMORY, and separately during FAULT -> next edge stateOut=0, all outputs 0, counters 0. instrReady held low in FETCH holds state 1 with fetchEnable=1.
